// File: rtl/prince_dec_iter.sv
// PRINCE block decryption, one round per clock.
// Accepts a ciphertext and a 128-bit key, runs 11 cycles on a shared round
// datapath and holds the plaintext until the consumer takes it.
module prince_dec_iter (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [63:0]  in_data_i,
  input  logic [127:0] in_key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [63:0]  out_data_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;

  function automatic logic [63:0] rc(input logic [3:0] idx);
    case (idx)
      4'd1:    rc = 64'h13198a2e03707344;
      4'd2:    rc = 64'ha4093822299f31d0;
      4'd3:    rc = 64'h082efa98ec4e6c89;
      4'd4:    rc = 64'h452821e638d01377;
      4'd5:    rc = 64'hbe5466cf34e90c6c;
      4'd6:    rc = 64'h7ef84f78fd955cb1;
      4'd7:    rc = 64'h85840851f1ac43aa;
      4'd8:    rc = 64'hc882d32f25323c54;
      4'd9:    rc = 64'h64a51195e0e3610d;
      4'd10:   rc = 64'hd3b5a399ca0c2399;
      4'd11:   rc = 64'hc0ac29b7c97c50dd;
      default: rc = 64'h0000000000000000;
    endcase
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hb;  4'h1: sbox = 4'hf;  4'h2: sbox = 4'h3;  4'h3: sbox = 4'h2;
      4'h4: sbox = 4'ha;  4'h5: sbox = 4'hc;  4'h6: sbox = 4'h9;  4'h7: sbox = 4'h1;
      4'h8: sbox = 4'h6;  4'h9: sbox = 4'h7;  4'ha: sbox = 4'h8;  4'hb: sbox = 4'h0;
      4'hc: sbox = 4'he;  4'hd: sbox = 4'h5;  4'he: sbox = 4'hd;  4'hf: sbox = 4'h4;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'hb;  4'h1: sbox_inv = 4'h7;  4'h2: sbox_inv = 4'h3;  4'h3: sbox_inv = 4'h2;
      4'h4: sbox_inv = 4'hf;  4'h5: sbox_inv = 4'hd;  4'h6: sbox_inv = 4'h8;  4'h7: sbox_inv = 4'h9;
      4'h8: sbox_inv = 4'ha;  4'h9: sbox_inv = 4'h6;  4'ha: sbox_inv = 4'h4;  4'hb: sbox_inv = 4'h0;
      4'hc: sbox_inv = 4'h5;  4'hd: sbox_inv = 4'he;  4'he: sbox_inv = 4'hc;  4'hf: sbox_inv = 4'h1;
      default: sbox_inv = 4'h0;
    endcase
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
    for (int n = 0; n < 16; n++) begin
      s_layer[4*n +: 4] = inv ? sbox_inv(x[4*n +: 4]) : sbox(x[4*n +: 4]);
    end
  endfunction

  // One 16-bit block of M': output nibble r = XOR_c m_((r+c+off) mod 4)(nibble c),
  // where m_k clears bit position k (position 0 = nibble MSB). off=0 -> M0, off=1 -> M1.
  function automatic logic [15:0] m_quarter(input logic [15:0] x, input logic [1:0] off);
    logic [3:0] acc;
    logic [1:0] k;
    m_quarter = 16'h0000;
    for (int r = 0; r < 4; r++) begin
      acc = 4'h0;
      for (int c = 0; c < 4; c++) begin
        k   = 2'(r + c) + off;
        acc = acc ^ (x[15-4*c -: 4] & ~(4'b1000 >> k));
      end
      m_quarter[15-4*r -: 4] = acc;
    end
  endfunction

  function automatic logic [63:0] mprime(input logic [63:0] x);
    mprime = {m_quarter(x[63:48], 2'd0), m_quarter(x[47:32], 2'd1),
              m_quarter(x[31:16], 2'd1), m_quarter(x[15:0],  2'd0)};
  endfunction

  // Nibble 0 sits at [63:60]; forward picks nibble 5j, inverse picks 13j (mod 16).
  function automatic logic [63:0] sr_layer(input logic [63:0] x, input logic inv);
    for (int j = 0; j < 16; j++) begin
      if (inv) begin
        sr_layer[63-4*j -: 4] = x[63-4*((13*j)%16) -: 4];
      end else begin
        sr_layer[63-4*j -: 4] = x[63-4*((5*j)%16) -: 4];
      end
    end
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] data_q, data_d;
  logic [63:0] k0_q, k0_d;
  logic [63:0] k1a_q, k1a_d;
  logic [63:0] out_data_q, out_data_d;

  logic [63:0] k0_in_s, k0p_s, k1a_in_s;
  logic [63:0] m_in_s, m_out_s, round_s;

  // Whitening keys derived from the offered key (only used at accept).
  always_comb begin
    k0_in_s  = in_key_i[127:64];
    k0p_s    = {k0_in_s[0], k0_in_s[63:1]} ^ {63'd0, k0_in_s[63]};
    k1a_in_s = in_key_i[63:0] ^ ALPHA;
  end

  // Shared round: rounds 1..6 start with S, rounds 7..11 start with key add + SRinv.
  always_comb begin
    if (rnd_q <= 4'd6) begin
      m_in_s = s_layer(data_q, 1'b0);
    end else begin
      m_in_s = sr_layer(data_q ^ k1a_q ^ rc(rnd_q - 4'd1), 1'b1);
    end
    m_out_s = mprime(m_in_s);
    if (rnd_q <= 4'd5) begin
      round_s = sr_layer(m_out_s, 1'b0) ^ rc(rnd_q) ^ k1a_q;
    end else if (rnd_q == 4'd11) begin
      round_s = s_layer(m_out_s, 1'b1) ^ rc(4'd11) ^ k1a_q ^ k0_q;
    end else begin
      round_s = s_layer(m_out_s, 1'b1);
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    data_d     = data_q;
    k0_d       = k0_q;
    k1a_d      = k1a_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = RUN;
          rnd_d   = 4'd1;
          data_d  = in_data_i ^ k0p_s ^ k1a_in_s ^ rc(4'd0);
          k0_d    = k0_in_s;
          k1a_d   = k1a_in_s;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        data_d = round_s;
        if (rnd_q == 4'd11) begin
          state_d    = DONE;
          out_data_d = round_s;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rnd_q      <= 4'd0;
      data_q     <= 64'd0;
      k0_q       <= 64'd0;
      k1a_q      <= 64'd0;
      out_data_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      data_q     <= data_d;
      k0_q       <= k0_d;
      k1a_q      <= k1a_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_prince_dec_iter.sv
// Self-checking bench for prince_dec_iter with a PRINCE reference model.
module tb_prince_dec_iter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [63:0]  in_data_i;
  logic [127:0] in_key_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [63:0]  out_data_o;

  int checks   = 0;
  int failures = 0;

  prince_dec_iter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_key_i    (in_key_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;
  localparam logic [63:0] RC [12] = '{
    64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
    64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
    64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
    64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd};
  localparam logic [3:0] SB [16] = '{4'hb, 4'hf, 4'h3, 4'h2, 4'ha, 4'hc, 4'h9, 4'h1,
                                     4'h6, 4'h7, 4'h8, 4'h0, 4'he, 4'h5, 4'hd, 4'h4};
  // Column images of M0 / M1 for input bit i (bit 0 = LSB of a 16-bit quarter).
  localparam logic [15:0] M0C [16] = '{16'h0111, 16'h2220, 16'h4404, 16'h8088,
                                       16'h1011, 16'h0222, 16'h4440, 16'h8808,
                                       16'h1101, 16'h2022, 16'h0444, 16'h8880,
                                       16'h1110, 16'h2202, 16'h4044, 16'h0888};
  localparam logic [15:0] M1C [16] = '{16'h1110, 16'h2202, 16'h4044, 16'h0888,
                                       16'h0111, 16'h2220, 16'h4404, 16'h8088,
                                       16'h1011, 16'h0222, 16'h4440, 16'h8808,
                                       16'h1101, 16'h2022, 16'h0444, 16'h8880};

  function automatic logic [3:0] ref_sinv_nib(input logic [3:0] x);
    logic [3:0] r;
    r = 4'h0;
    for (int v = 0; v < 16; v++) if (SB[v] == x) r = 4'(v);
    return r;
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = inv ? ref_sinv_nib(x[4*n +: 4]) : SB[x[4*n +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] ref_mp(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < 16; i++)
        if (x[16*q + i]) y[16*q +: 16] = y[16*q +: 16] ^ ((q == 1 || q == 2) ? M1C[i] : M0C[i]);
    return y;
  endfunction

  function automatic logic [63:0] ref_shift(input logic [63:0] x, input int mult);
    logic [3:0] nib [16];
    logic [63:0] y;
    for (int j = 0; j < 16; j++) nib[j] = x[63-4*j -: 4];
    for (int j = 0; j < 16; j++) y[63-4*j -: 4] = nib[(mult*j) % 16];
    return y;
  endfunction

  // PRINCE-Enc with explicit pre/post whitening keys; decryption swaps them and uses k1^alpha.
  function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [63:0] kin,
                                          input logic [63:0] kout, input logic [63:0] k1);
    logic [63:0] s;
    s = p ^ kin ^ k1 ^ RC[0];
    for (int i = 1; i <= 5; i++) s = ref_shift(ref_mp(ref_sub(s, 0)), 5) ^ RC[i] ^ k1;
    s = ref_sub(ref_mp(ref_sub(s, 0)), 1);
    for (int i = 6; i <= 10; i++) s = ref_sub(ref_mp(ref_shift(s ^ k1 ^ RC[i], 13)), 1);
    return s ^ RC[11] ^ k1 ^ kout;
  endfunction

  function automatic logic [63:0] ref_dec(input logic [63:0] c, input logic [127:0] key);
    logic [63:0] k0, k0p;
    k0  = key[127:64];
    k0p = {k0[0], k0[63:1]} ^ (k0 >> 63);
    return ref_enc(c, k0p, k0, key[63:0] ^ ALPHA);
  endfunction

  // ---------------- helpers ----------------
  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check64({tag, "_ready"}, 64'(in_ready_o), 64'd1);
  endtask

  // Offer one job, check latency and result, then drain it.
  task automatic run_job(input string tag, input logic [63:0] d, input logic [127:0] k,
                         input logic [63:0] exp);
    int n;
    wait_ready(tag);
    in_data_i  = d;
    in_key_i   = k;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_data_i  = rnd64();
    in_key_i   = {rnd64(), rnd64()};
    n = 0;
    while (out_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check64({tag, "_latency"}, 64'(n), 64'd11);
    check64({tag, "_data"}, out_data_o, exp);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check64({tag, "_drained"}, 64'(out_valid_o), 64'd0);
  endtask

  logic [63:0]  d, held, exp_q [$];
  logic [127:0] k;
  bit           seen;
  int           n, cyc, last, results;

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    in_data_i   = 64'd0;
    in_key_i    = 128'd0;
    repeat (2) @(negedge clk_i);
    check64("rst_in_ready", 64'(in_ready_o), 64'd1);
    check64("rst_out_valid", 64'(out_valid_o), 64'd0);
    check64("rst_out_data", out_data_o, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Known-answer vectors.
    run_job("kat0", 64'h818665aa0d02dfda, 128'd0, 64'h0000000000000000);
    run_job("kat1", 64'h604ae6ca03c20ada, 128'd0, 64'hffffffffffffffff);
    run_job("kat2", 64'h9fb51935fc3df524, {64'hffffffffffffffff, 64'd0}, 64'h0000000000000000);
    run_job("kat3", 64'hae25ad3ca8fa9ccf, {64'd0, 64'hfedcba9876543210}, 64'h0123456789abcdef);
    run_job("kat4", 64'h78a54cbe737bb7ef, {64'd0, 64'hffffffffffffffff}, 64'h0000000000000000);

    // Random jobs against the model.
    for (int i = 0; i < 6; i++) begin
      d = rnd64();
      k = {rnd64(), rnd64()};
      run_job("rand", d, k, ref_dec(d, k));
    end

    // Hold in DONE for 20 cycles with in_valid noise.
    d = rnd64();
    k = {rnd64(), rnd64()};
    wait_ready("hold");
    in_data_i = d; in_key_i = k; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    n = 0;
    while (out_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    held = ref_dec(d, k);
    for (int i = 0; i < 20; i++) begin
      check64("hold_valid", 64'(out_valid_o), 64'd1);
      check64("hold_data", out_data_o, held);
      in_valid_i = i[0];
      in_data_i  = rnd64();
      in_key_i   = {rnd64(), rnd64()};
      @(negedge clk_i);
    end
    in_valid_i  = 1'b0;
    check64("hold_busy", 64'(in_ready_o), 64'd0);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check64("hold_release_valid", 64'(out_valid_o), 64'd0);
    check64("hold_release_ready", 64'(in_ready_o), 64'd1);
    d = rnd64(); k = {rnd64(), rnd64()};
    run_job("after_hold", d, k, ref_dec(d, k));

    // Reset during RUN cycle 5 with in_valid and out_ready also high.
    wait_ready("abort");
    in_data_i = rnd64(); in_key_i = {rnd64(), rnd64()}; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    check64("abort_ready", 64'(in_ready_o), 64'd1);
    check64("abort_data", out_data_o, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o === 1'b1) seen = 1'b1;
      @(negedge clk_i);
    end
    check64("abort_no_output", 64'(seen), 64'd0);
    d = rnd64(); k = {rnd64(), rnd64()};
    run_job("after_abort", d, k, ref_dec(d, k));

    // Back-to-back with in_valid held high and out_ready always 1.
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    results = 0; last = -1; cyc = 0;
    while (results < 4 && cyc < 200) begin
      if (out_valid_o === 1'b1) begin
        check64("b2b_data", out_data_o, (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data_o);
        if (last >= 0) check64("b2b_spacing", 64'(cyc - last), 64'd13);
        last = cyc;
        results++;
      end
      d = rnd64();
      k = {rnd64(), rnd64()};
      in_data_i = d;
      in_key_i  = k;
      if (in_ready_o === 1'b1) exp_q.push_back(ref_dec(d, k));
      @(negedge clk_i);
      cyc++;
    end
    in_valid_i  = 1'b0;
    check64("b2b_count", 64'(results), 64'd4);
    repeat (3) @(negedge clk_i);
    out_ready_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prince_dec_iter.md
PRINCE_DEC_ITER -- requirements
Module: prince_dec_iter

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 64-bit block, 128-bit key.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-004 in_valid  in  1  ciphertext/key offered.
REQ-005 in_ready  out  1  block can accept a new job.
REQ-006 in_data  in  64  ciphertext; nibble 0 = bits [63:60].
REQ-007 in_key  in  128  k0 = [127:64], k1 = [63:0].
REQ-008 out_valid  out  1  plaintext available.
REQ-009 out_ready  in  1  consumer accepts plaintext.
REQ-010 out_data  out  64  recovered plaintext.

Function
REQ-011 The block SHALL compute PRINCE decryption: P = PRINCE-Enc with k0 and k0' swapped and k1 replaced by k1a = k1 ^ c0ac29b7c97c50dd; k0' = (k0 >>> 1) ^ (k0 >> 63).
REQ-012 FSM states SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 Accept SHALL occur on an edge with IDLE & in_valid; key and data are captured then and later input changes are ignored.
REQ-014 At accept, state <= in_data ^ k0' ^ k1a ^ RC0; round counter r <= 1; IDLE -> RUN.
REQ-015 RUN, r = 1..5: forward round, state <= SR(M'(S(state))) ^ RC_r ^ k1a.
REQ-016 RUN, r = 6: middle, state <= Sinv(M'(S(state))).
REQ-017 RUN, r = 7..11: inverse round using RC_(r-1), i.e. RC6..RC10, state <= Sinv(M'(SRinv(state ^ k1a ^ RC_(r-1)))); at r = 11 the result is additionally XORed with RC11 ^ k1a ^ k0 and the FSM goes RUN -> DONE.
REQ-018 Latency: accept edge T0; out_valid SHALL rise after edge T11 (exactly 11 RUN cycles).
REQ-019 DONE: out_data and out_valid SHALL be held stable until a clock edge with out_ready = 1; that edge moves DONE -> IDLE; in_ready rises the following cycle, with no same-cycle accept.
REQ-020 out_ready while not DONE SHALL have no effect; in_valid outside IDLE SHALL be ignored and no job queued.
REQ-021 S box SHALL be B F 3 2 A C 9 1 6 7 8 0 E 5 D 4, with inverse Sinv, applied per nibble.
REQ-022 M' SHALL be the standard PRINCE involutive block matrix diag(M0,M1,M1,M0) over 16-bit quarters; it is its own inverse.
REQ-023 SR: output nibble j = input nibble (5j mod 16); SRinv: output nibble j = input nibble (13j mod 16).
REQ-024 RC0..RC11 SHALL be 0, 13198a2e03707344, a4093822299f31d0, 082efa98ec4e6c89, 452821e638d01377, be5466cf34e90c6c, 7ef84f78fd955cb1, 85840851f1ac43aa, c882d32f25323c54, 64a51195e0e3610d, d3b5a399ca0c2399, c0ac29b7c97c50dd.
REQ-025 One round datapath SHALL be shared by all cycles; the counter stops at 11 and does not wrap.

Reset
REQ-026 On a clock edge with rst_n = 0: FSM -> IDLE, r -> 0, state and out_data -> 0, out_valid -> 0, in_ready -> 1 from the next cycle.
REQ-027 Reset mid-RUN or in DONE SHALL abort the job with no output produced; the job is never resumed.
REQ-028 Reset SHALL take priority over simultaneous in_valid/out_ready.

Verification
REQ-029 in_data 818665aa0d02dfda, key 0 -> out_data 0000000000000000 after 11 cycles.
REQ-030 in_data 604ae6ca03c20ada, key 0 -> ffffffffffffffff; in_data 9fb51935fc3df524, k0 = all-ones, k1 = 0 -> 0.
REQ-031 in_data ae25ad3ca8fa9ccf, k0 = 0, k1 = fedcba9876543210 -> 0123456789abcdef; in_data 78a54cbe737bb7ef, k0 = 0, k1 = all-ones -> 0.
REQ-032 out_ready held 0 for 20 cycles in DONE -> out_valid and out_data stable; in_valid pulses ignored; after out_ready, in_ready returns and the next job is correct.
REQ-033 rst_n low at RUN cycle 5 -> out_valid never asserted; in_ready 1 after reset; a fresh job decrypts correctly.
REQ-034 Back-to-back jobs with in_valid held high and out_ready always 1 -> one result per 13 cycles, each correct, in order.
